// File: rtl/td4x_cpu.sv
// td4x_cpu: parametrised TD4-style core with handshaked instruction fetch,
// zero/carry flags, conditional jumps, output strobe and an absorbing halt.
module td4x_cpu #(
  parameter int W      = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  output logic              fetch_req,
  input  logic [W+3:0]      data,
  input  logic              data_valid,
  input  logic [W-1:0]      io_in,
  output logic [W-1:0]      io_out,
  output logic              out_strobe,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

  state_e            state_q, state_d;
  logic [W+3:0]      instr_q, instr_d;
  logic [W-1:0]      regA_q, regA_d;
  logic [W-1:0]      regB_q, regB_d;
  logic [W-1:0]      outReg_q, outReg_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] ip_q, ip_d;

  logic [3:0]        opcode;
  logic [W-1:0]      imm;
  logic [ADDR_W-1:0] ipInc;
  logic [ADDR_W-1:0] jumpTarget;
  logic [W:0]        sumAImm;
  logic [W:0]        sumBImm;
  logic [W:0]        sumAB;
  logic [W-1:0]      diffAImm;

  assign opcode   = instr_q[W+3:W];
  assign imm      = instr_q[W-1:0];
  assign ipInc    = ip_q + ADDR_W'(1);
  assign sumAImm  = {1'b0, regA_q} + {1'b0, imm};
  assign sumBImm  = {1'b0, regB_q} + {1'b0, imm};
  assign sumAB    = {1'b0, regA_q} + {1'b0, regB_q};
  assign diffAImm = regA_q - imm;

  // Jump targets truncate the immediate, or zero-extend it for wide address spaces.
  if (ADDR_W <= W) begin : g_jumpTrunc
    assign jumpTarget = imm[ADDR_W-1:0];
  end else begin : g_jumpExt
    assign jumpTarget = {{(ADDR_W-W){1'b0}}, imm};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      regA_q   <= '0;
      regB_q   <= '0;
      outReg_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      strobe_q <= 1'b0;
      ip_q     <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      regA_q   <= regA_d;
      regB_q   <= regB_d;
      outReg_q <= outReg_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      strobe_q <= strobe_d;
      ip_q     <= ip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    regA_d   = regA_q;
    regB_d   = regB_q;
    outReg_d = outReg_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    strobe_d = 1'b0;
    ip_d     = ip_q;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (data_valid) begin
          instr_d = data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Flags only survive one instruction, so every EXEC starts from cleared flags.
        state_d = FETCH;
        ip_d    = ipInc;
        cf_d    = 1'b0;
        zf_d    = 1'b0;
        case (opcode)
          4'b0000: begin
            regA_d = sumAImm[W-1:0];
            cf_d   = sumAImm[W];
            zf_d   = (sumAImm[W-1:0] == '0);
          end
          4'b0101: begin
            regB_d = sumBImm[W-1:0];
            cf_d   = sumBImm[W];
            zf_d   = (sumBImm[W-1:0] == '0);
          end
          4'b1101: begin
            regA_d = sumAB[W-1:0];
            cf_d   = sumAB[W];
            zf_d   = (sumAB[W-1:0] == '0);
          end
          4'b1000: begin
            regA_d = diffAImm;
            cf_d   = (imm > regA_q);
            zf_d   = (diffAImm == '0);
          end
          4'b0011: regA_d = imm;
          4'b0111: regB_d = imm;
          4'b0001: regA_d = regB_q;
          4'b0100: regB_d = regA_q;
          4'b0010: regA_d = io_in;
          4'b0110: regB_d = io_in;
          4'b1001: begin
            outReg_d = regB_q;
            strobe_d = 1'b1;
          end
          4'b1011: begin
            outReg_d = imm;
            strobe_d = 1'b1;
          end
          4'b1111: ip_d = jumpTarget;
          4'b1110: if (!cf_q) ip_d = jumpTarget;
          4'b1100: if (zf_q) ip_d = jumpTarget;
          4'b1010: begin
            ip_d    = ip_q;
            state_d = HALT;
          end
          default: ;
        endcase
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  assign address    = ip_q;
  assign fetch_req  = (state_q == FETCH);
  assign io_out     = outReg_q;
  assign out_strobe = strobe_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_td4x_cpu.sv
// Self-checking bench for td4x_cpu: program table, ISA-level reference model
// with random wait states and inputs, plus wide-config and async-reset sequences.
module tb_td4x_cpu;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rstN;
  logic [3:0] addr4;
  logic       fetch4;
  logic [7:0] data4;
  logic       valid4;
  logic [3:0] io4;
  logic [3:0] out4;
  logic       strobe4;
  logic       halt4;
  logic [7:0] rom4 [16];
  assign data4 = rom4[addr4];

  logic [5:0]  addr8;
  logic        fetch8;
  logic [11:0] data8;
  logic        valid8;
  logic [7:0]  io8;
  logic [7:0]  out8;
  logic        strobe8;
  logic        halt8;
  logic [11:0] rom8 [64];
  assign data8 = rom8[addr8];

  td4x_cpu #(.W(4), .ADDR_W(4)) dut4 (
    .clock(clock), .reset(rstN), .address(addr4), .fetch_req(fetch4),
    .data(data4), .data_valid(valid4), .io_in(io4), .io_out(out4),
    .out_strobe(strobe4), .halted(halt4)
  );

  td4x_cpu #(.W(8), .ADDR_W(6)) dut8 (
    .clock(clock), .reset(rstN), .address(addr8), .fetch_req(fetch8),
    .data(data8), .data_valid(valid8), .io_in(io8), .io_out(out8),
    .out_strobe(strobe8), .halted(halt8)
  );

  int total = 0;
  int bad   = 0;

  // Architectural state of the 4-bit machine, advanced one whole instruction at a time.
  int mA, mB, mCf, mZf, mIp, mOut, mHalt, mStrobe;

  typedef struct {
    logic [15:0][7:0] rom;
    int mode;
    int expOut;
    int expAddr;
    int expStrobes;
    int expCycles;
  } vec_t;

  vec_t tbl[6];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic modelExec(input logic [7:0] ins, input int io);
    int op, imm, nip, cf, zf, s;
    op = int'(ins[7:4]);
    imm = int'(ins[3:0]);
    nip = (mIp + 1) % 16;
    cf = 0;
    zf = 0;
    mStrobe = 0;
    case (op)
      0:  begin s = mA + imm; cf = (s > 15); mA = s % 16; zf = (mA == 0); end
      5:  begin s = mB + imm; cf = (s > 15); mB = s % 16; zf = (mB == 0); end
      13: begin s = mA + mB;  cf = (s > 15); mA = s % 16; zf = (mA == 0); end
      8:  begin cf = (imm > mA); mA = (mA - imm + 16) % 16; zf = (mA == 0); end
      3:  mA = imm;
      7:  mB = imm;
      1:  mA = mB;
      4:  mB = mA;
      2:  mA = io;
      6:  mB = io;
      9:  begin mOut = mB; mStrobe = 1; end
      11: begin mOut = imm; mStrobe = 1; end
      15: nip = imm;
      14: if (mCf == 0) nip = imm;
      12: if (mZf == 1) nip = imm;
      10: begin nip = mIp; mHalt = 1; end
      default: ;
    endcase
    mCf = cf;
    mZf = zf;
    mIp = nip;
  endtask

  task automatic doReset();
    valid4 = 1'b0;
    valid8 = 1'b0;
    rstN = 1'b0;
    #2;
    checkOutput("rstAddr", int'(addr4), 0);
    checkOutput("rstFetch", int'(fetch4), 0);
    checkOutput("rstOut", int'(out4), 0);
    checkOutput("rstStrobe", int'(strobe4), 0);
    checkOutput("rstHalt", int'(halt4), 0);
    checkOutput("rstOut8", int'(out8), 0);
    tick();
    rstN = 1'b1;
    checkOutput("idleFetch", int'(fetch4), 0);
    tick();
  endtask

  // mode 0: data_valid held high; 1: valid on every 3rd FETCH cycle; 2: random.
  task automatic applyStimulus(input int mode, input int budget, input bit needHalt,
                               output int dutHalt, output int strobes);
    int fetchCnt, expStrobe;
    bit execNext;
    logic [7:0] ir;
    doReset();
    mA = 0; mB = 0; mCf = 0; mZf = 0; mIp = 0; mOut = 0; mHalt = 0;
    fetchCnt = 0;
    expStrobe = 0;
    execNext = 1'b0;
    ir = 8'h00;
    dutHalt = -1;
    strobes = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      checkOutput("fetch_req", int'(fetch4), int'(mHalt == 0 && !execNext));
      checkOutput("halted", int'(halt4), mHalt);
      checkOutput("address", int'(addr4), mIp);
      checkOutput("io_out", int'(out4), mOut);
      checkOutput("out_strobe", int'(strobe4), expStrobe);
      if (strobe4) strobes++;
      if (halt4 && dutHalt < 0) dutHalt = cyc;
      if (mHalt != 0) break;
      io4 = 4'($urandom_range(0, 15));
      expStrobe = 0;
      if (execNext) begin
        valid4 = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        modelExec(ir, int'(io4));
        expStrobe = mStrobe;
        execNext = 1'b0;
      end else begin
        case (mode)
          0: valid4 = 1'b1;
          1: begin valid4 = (fetchCnt % 3 == 2); fetchCnt++; end
          default: valid4 = ($urandom_range(0, 3) == 0);
        endcase
        if (valid4) begin
          ir = rom4[mIp];
          execNext = 1'b1;
        end
      end
      tick();
    end
    if (needHalt && mHalt == 0) checkOutput("haltTimeout", int'(halt4), 1);
    valid4 = 1'b0;
  endtask

  initial begin
    int hc, st;
    rstN = 1'b1;
    valid4 = 1'b0;
    valid8 = 1'b0;
    io4 = 4'h0;
    io8 = 8'h00;
    for (int i = 0; i < 16; i++) rom4[i] = 8'hA0;
    for (int i = 0; i < 64; i++) rom8[i] = 12'hA00;

    for (int k = 0; k < 6; k++) tbl[k].rom = {16{8'hA0}};
    tbl[0].rom[4:0] = {8'hA0, 8'hB9, 8'hE0, 8'h0E, 8'h33};
    tbl[0].mode = 0; tbl[0].expOut = 9; tbl[0].expAddr = 4; tbl[0].expStrobes = 1; tbl[0].expCycles = 10;
    tbl[1].rom = tbl[0].rom;
    tbl[1].mode = 1; tbl[1].expOut = 9; tbl[1].expAddr = 4; tbl[1].expStrobes = 1; tbl[1].expCycles = 20;
    tbl[2].rom[4:0]  = {8'hA0, 8'hB1, 8'hC7, 8'h85, 8'h35};
    tbl[2].rom[12:7] = {8'hB3, 8'hA0, 8'h90, 8'h40, 8'hEC, 8'h81};
    tbl[2].mode = 0; tbl[2].expOut = 15; tbl[2].expAddr = 11; tbl[2].expStrobes = 1; tbl[2].expCycles = 16;
    tbl[3].rom[9:0] = {8'hA0, 8'h90, 8'hEA, 8'h59, 8'hA0, 8'hB1, 8'hC6, 8'hD0, 8'h77, 8'h39};
    tbl[3].mode = 0; tbl[3].expOut = 0; tbl[3].expAddr = 9; tbl[3].expStrobes = 1; tbl[3].expCycles = 16;
    tbl[4].rom[8:0] = {8'hA0, 8'h90, 8'hBC, 8'hB5, 8'hE6, 8'hC8, 8'h72, 8'h01, 8'h3F};
    tbl[4].mode = 1; tbl[4].expOut = 2; tbl[4].expAddr = 8; tbl[4].expStrobes = 2; tbl[4].expCycles = 32;
    tbl[5].rom[5:0] = {8'hA0, 8'h90, 8'h40, 8'h8C, 8'h10, 8'h7B};
    tbl[5].mode = 0; tbl[5].expOut = 15; tbl[5].expAddr = 5; tbl[5].expStrobes = 1; tbl[5].expCycles = 12;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) rom4[i] = tbl[k].rom[i];
      applyStimulus(tbl[k].mode, 200, 1'b1, hc, st);
      checkOutput($sformatf("tbl%0d_out", k), int'(out4), tbl[k].expOut);
      checkOutput($sformatf("tbl%0d_addr", k), int'(addr4), tbl[k].expAddr);
      checkOutput($sformatf("tbl%0d_strobes", k), st, tbl[k].expStrobes);
      checkOutput($sformatf("tbl%0d_cycles", k), hc, tbl[k].expCycles);
      tick();
      checkOutput($sformatf("tbl%0d_stayHalted", k), int'(halt4), 1);
      checkOutput($sformatf("tbl%0d_noFetch", k), int'(fetch4), 0);
    end

    // All-JZ ROM never jumps (ZF is always cleared by the JZ itself), so IP wraps.
    for (int i = 0; i < 16; i++) rom4[i] = 8'hC0;
    applyStimulus(2, 160, 1'b0, hc, st);
    applyStimulus(0, 70, 1'b0, hc, st);
    checkOutput("wrapAddr", int'(addr4), 3);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) rom4[i] = 8'($urandom);
      applyStimulus(2, 300, 1'b0, hc, st);
    end

    // Wide configuration: 200+100 carries out to 44, JMP 0xFF truncates to 63.
    rom8[0] = 12'h0C8; rom8[1] = 12'h064; rom8[2] = 12'hE0A; rom8[3] = 12'h400;
    rom8[4] = 12'h900; rom8[5] = 12'hFFF; rom8[10] = 12'hBEE; rom8[63] = 12'hA00;
    doReset();
    valid8 = 1'b1;
    hc = -1;
    st = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (strobe8) st++;
      if (halt8) begin hc = cyc; break; end
      tick();
    end
    valid8 = 1'b0;
    checkOutput("wideOut", int'(out8), 44);
    checkOutput("wideAddr", int'(addr8), 63);
    checkOutput("wideStrobes", st, 1);
    checkOutput("wideCycles", hc, 14);

    // Asynchronous reset during EXEC of OUT imm 6, then during a FETCH.
    rom4[0] = 8'hB6;
    rom4[1] = 8'hA0;
    doReset();
    valid4 = 1'b1;
    tick();
    checkOutput("execFetchLow", int'(fetch4), 0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midExecOut", int'(out4), 0);
    checkOutput("midExecStrobe", int'(strobe4), 0);
    checkOutput("midExecAddr", int'(addr4), 0);
    checkOutput("midExecFetch", int'(fetch4), 0);
    tick();
    checkOutput("heldStrobe", int'(strobe4), 0);
    checkOutput("heldOut", int'(out4), 0);
    valid4 = 1'b0;
    rstN = 1'b1;
    tick();
    checkOutput("restartFetch", int'(fetch4), 1);
    checkOutput("restartAddr", int'(addr4), 0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midFetchFetch", int'(fetch4), 0);
    tick();
    rstN = 1'b1;
    tick();
    valid4 = 1'b1;
    tick();
    tick();
    checkOutput("afterOutStrobe", int'(strobe4), 1);
    checkOutput("afterOutValue", int'(out4), 6);
    checkOutput("afterOutAddr", int'(addr4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
